// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode values, immediate formats,
// the per-opcode control bundle and the helpers that build them.
package decode_pkg;

  // Base opcodes recognised by the decoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Immediate layout selected by the opcode; NONE yields a zero immediate
  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Control fields derived from the opcode alone
  typedef struct packed {
    logic      legal;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      writes_rd;
    imm_type_e imm_type;
  } ctrl_t;

  // Classify an opcode into its operand usage and immediate format
  function automatic ctrl_t decode_opcode(input logic [6:0] opcode);
    ctrl_t c;
    c.legal     = 1'b1;
    c.uses_rs1  = 1'b0;
    c.uses_rs2  = 1'b0;
    c.writes_rd = 1'b0;
    c.imm_type  = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
        c.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        c.uses_rs1  = 1'b1;
        c.writes_rd = 1'b1;
        c.imm_type  = IMM_I;
      end
      OPC_STORE: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.writes_rd = 1'b1;
        c.imm_type  = IMM_U;
      end
      OPC_JAL: begin
        c.writes_rd = 1'b1;
        c.imm_type  = IMM_J;
      end
      default: begin
        c.legal = 1'b0;
      end
    endcase
    return c;
  endfunction

  // Assemble the 32-bit sign-extended immediate for the given format
  function automatic logic [31:0] build_imm(input logic [31:0] instr,
                                            input imm_type_e   kind);
    logic [31:0] imm;
    case (kind)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set when a
// writing instruction issues and cleared when writeback retires it.
module scoreboard
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       busy_rs1,
  output logic       busy_rs2
);

  logic [31:0] pending;
  logic [31:0] pending_next;

  // Next mask: clear first so a same-cycle set of the same index wins; x0 never pends
  always_comb begin
    pending_next = pending;
    if (clr_en) begin
      pending_next[clr_idx] = 1'b0;
    end
    if (set_en) begin
      pending_next[set_idx] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // A source is busy if pending, unless writeback retires it this very cycle
  always_comb begin
    busy_rs1 = (rs1 != 5'd0) && pending[rs1] && !(clr_en && (clr_idx == rs1));
    busy_rs2 = (rs2 != 5'd0) && pending[rs2] && !(clr_en && (clr_idx == rs2));
  end

  // Pending mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 32'b0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits instructions into register addresses, control fields
// and immediates, stalls on read-after-write hazards and holds the result in
// a single valid/ready output register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic [31:0]        instr_i,
  input  logic [BITSIZE-1:0] pc_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  input  logic [BITSIZE-1:0] data_rs1_i,
  input  logic [BITSIZE-1:0] data_rs2_i,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BITSIZE-1:0] pc_o,
  output logic [BITSIZE-1:0] rs1_data_o,
  output logic [BITSIZE-1:0] rs2_data_o,
  output logic [BITSIZE-1:0] imm_o,
  output logic [4:0]         rd_o,
  output logic [6:0]         opcode_o,
  output logic [2:0]         funct3_o,
  output logic               funct7b5_o,
  output logic               illegal_o
);

  ctrl_t              ctrl;
  logic [4:0]         rd_dec;
  logic [31:0]        imm32;
  logic [BITSIZE-1:0] imm_ext;
  logic               busy_rs1;
  logic               busy_rs2;
  logic               hazard_rs1;
  logic               hazard_rs2;
  logic               accept;
  logic               issue;
  logic               sb_set;
  logic               sb_clr;

  // Register file addresses come straight from the instruction word
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];

  // Decode the incoming instruction; non-writing instructions report rd = 0
  always_comb begin
    ctrl   = decode_opcode(instr_i[6:0]);
    rd_dec = ctrl.writes_rd ? instr_i[11:7] : 5'd0;
    imm32  = build_imm(instr_i, ctrl.imm_type);
  end

  // Widen the immediate to the datapath width by replicating its sign bit
  always_comb begin
    imm_ext        = {BITSIZE{imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  // A used source is hazardous if still pending or produced by the held instruction
  always_comb begin
    hazard_rs1 = ctrl.uses_rs1 && (rs1_o != 5'd0) &&
                 (busy_rs1 || (valid_o && (rd_o == rs1_o)));
    hazard_rs2 = ctrl.uses_rs2 && (rs2_o != 5'd0) &&
                 (busy_rs2 || (valid_o && (rd_o == rs2_o)));
  end

  // Handshake: ready never looks at valid_i, so fetch cannot form a loop through it
  always_comb begin
    ready_o = !flush_i && !hazard_rs1 && !hazard_rs2 && (!valid_o || ready_i);
    accept  = valid_i && ready_o;
    issue   = valid_o && ready_i && !flush_i;
    sb_set  = issue && (rd_o != 5'd0);
    sb_clr  = wb_valid_i && (wb_rd_i != 5'd0);
  end

  scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rstn_i),
    .set_en   (sb_set),
    .set_idx  (rd_o),
    .clr_en   (sb_clr),
    .clr_idx  (wb_rd_i),
    .rs1      (rs1_o),
    .rs2      (rs2_o),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );

  // Output register: flush drops the entry, accept loads, a lone issue empties
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rd_o       <= 5'd0;
      opcode_o   <= 7'd0;
      funct3_o   <= 3'd0;
      funct7b5_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o    <= 1'b1;
      pc_o       <= pc_i;
      rs1_data_o <= data_rs1_i;
      rs2_data_o <= data_rs2_i;
      imm_o      <= imm_ext;
      rd_o       <= rd_dec;
      opcode_o   <= instr_i[6:0];
      funct3_o   <= instr_i[14:12];
      funct7b5_o <= instr_i[30];
      illegal_o  <= !ctrl.legal;
    end else if (issue) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage with a directed prologue.
module tb_decode_stage;

  logic        clk;
  logic        rstn_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] data_rs1_i;
  logic [31:0] data_rs2_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic        illegal_o;

  decode_stage #(.BITSIZE(32)) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rs1_o      (rs1_o),
    .rs2_o      (rs2_o),
    .data_rs1_i (data_rs1_i),
    .data_rs2_i (data_rs2_i),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .pc_o       (pc_o),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .imm_o      (imm_o),
    .rd_o       (rd_o),
    .opcode_o   (opcode_o),
    .funct3_o   (funct3_o),
    .funct7b5_o (funct7b5_o),
    .illegal_o  (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
    bit          use1;
    bit          use2;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t expq[$];

  // reference model state
  bit         pend[32];
  bit         m_valid;
  logic [4:0] m_rd;
  exp_t       m_e;
  bit         m_haz;
  bit         m_ready;
  bit         m_acc;
  bit         m_iss;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode worked out from the instruction set rules with integer arithmetic
  function automatic exp_t refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    int   s;
    int   u;
    int   imm;
    bit   writes;
    s = $signed(ins);
    u = s;
    imm = 0;
    writes = 0;
    e.pc = pc; e.d1 = d1; e.d2 = d2;
    e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    e.ill = 1'b0; e.use1 = 0; e.use2 = 0;
    case (ins[6:0])
      7'h33: begin e.use1 = 1; e.use2 = 1; writes = 1; end
      7'h13, 7'h03, 7'h67: begin e.use1 = 1; writes = 1; imm = s >>> 20; end
      7'h23: begin
        e.use1 = 1; e.use2 = 1;
        imm = (s >>> 25) * 32 + ((u >> 7) & 31);
      end
      7'h63: begin
        e.use1 = 1; e.use2 = 1;
        imm = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048 +
              ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
      end
      7'h37, 7'h17: begin writes = 1; imm = (s >>> 12) * 4096; end
      7'h6F: begin
        writes = 1;
        imm = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 +
              ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
      end
      default: e.ill = 1'b1;
    endcase
    e.rd  = writes ? ins[11:7] : 5'd0;
    e.imm = imm;
    return e;
  endfunction

  function automatic bit hazardOn(input bit used, input logic [4:0] s);
    return used && (s != 5'd0) &&
           ((pend[s] && !(wb_valid_i && (wb_rd_i == s))) || (m_valid && (m_rd == s)));
  endfunction

  // Reference model: predicts ready/valid and pushes the expected output on each accept
  always @(negedge clk) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      m_valid = 0;
      m_rd = 5'd0;
      expq.delete();
      checkOutput("reset_valid", 32'(valid_o), 32'd0);
    end else begin
      m_e = refDecode(instr_i, pc_i, data_rs1_i, data_rs2_i);
      m_haz = hazardOn(m_e.use1, instr_i[19:15]) || hazardOn(m_e.use2, instr_i[24:20]);
      m_ready = !flush_i && !m_haz && (!m_valid || ready_i);
      checkOutput("ready", 32'(ready_o), 32'(m_ready));
      checkOutput("valid", 32'(valid_o), 32'(m_valid));
      m_acc = valid_i && m_ready;
      m_iss = m_valid && ready_i && !flush_i;
      if (wb_valid_i && wb_rd_i != 5'd0) pend[wb_rd_i] = 0;
      if (m_iss && m_rd != 5'd0) pend[m_rd] = 1;
      if (flush_i) begin
        m_valid = 0;
      end else if (m_acc) begin
        m_valid = 1;
        m_rd = m_e.rd;
        expq.push_back(m_e);
      end else if (m_iss) begin
        m_valid = 0;
      end
    end
  end

  // Monitor: compares the held entry with the oldest expectation, pops on issue or flush
  always @(negedge clk) begin
    if (rstn_i && valid_o) begin
      if (expq.size() == 0) begin
        checkOutput("entry_expected", 32'(expq.size()), 32'd1);
      end else begin
        checkOutput("pc", pc_o, expq[0].pc);
        checkOutput("rs1_data", rs1_data_o, expq[0].d1);
        checkOutput("rs2_data", rs2_data_o, expq[0].d2);
        checkOutput("imm", imm_o, expq[0].imm);
        checkOutput("ctrl", {16'd0, rd_o, opcode_o, funct3_o, funct7b5_o, illegal_o},
                    {16'd0, expq[0].rd, expq[0].op, expq[0].f3, expq[0].f7b5, expq[0].ill});
        if (flush_i || ready_i) void'(expq.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit vld, input logic [31:0] ins, input bit rdy,
                               input bit fl, input bit wbv, input logic [4:0] wbr,
                               input logic [31:0] d1);
    @(posedge clk);
    #1;
    valid_i    = vld;
    instr_i    = ins;
    pc_i       = ins + 32'h1000;
    ready_i    = rdy;
    flush_i    = fl;
    wb_valid_i = wbv;
    wb_rd_i    = wbr;
    data_rs1_i = d1;
    data_rs2_i = ~d1;
    @(negedge clk);
  endtask

  logic [6:0]  opTable [11];
  logic [31:0] rnd;
  bit          lastAcc;

  initial begin
    opTable = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};
    rstn_i = 0; valid_i = 0; instr_i = 0; pc_i = 0; ready_i = 0; flush_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; data_rs1_i = 0; data_rs2_i = 0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1;

    // store: negative S immediate, no destination
    applyStimulus(1, 32'hFE20AE23, 1, 0, 0, 0, 32'h11);
    checkOutput("sw_ready", 32'(ready_o), 32'd1);
    // addi x1,x0,5 back to back behind the store
    applyStimulus(1, 32'h00500093, 1, 0, 0, 0, 32'h22);
    checkOutput("sw_valid", 32'(valid_o), 32'd1);
    checkOutput("sw_imm", imm_o, 32'hFFFFFFFC);
    checkOutput("sw_rd", 32'(rd_o), 32'd0);
    checkOutput("addi_ready", 32'(ready_o), 32'd1);
    // add x3,x1,x2 depends on the addi
    applyStimulus(1, 32'h002081B3, 1, 0, 0, 0, 32'h33);
    checkOutput("addi_rd", 32'(rd_o), 32'd1);
    checkOutput("addi_imm", imm_o, 32'd5);
    checkOutput("addi_illegal", 32'(illegal_o), 32'd0);
    checkOutput("raw_stall0", 32'(ready_o), 32'd0);
    repeat (2) begin
      applyStimulus(1, 32'h002081B3, 1, 0, 0, 0, 32'h44);
      checkOutput("raw_stall", 32'(ready_o), 32'd0);
    end
    applyStimulus(1, 32'h002081B3, 1, 0, 1, 5'd1, 32'h12345678);
    checkOutput("raw_release", 32'(ready_o), 32'd1);
    // execute back-pressure for three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h002081B3, 0, 0, 0, 0, 32'h55);
      checkOutput("hold_valid", 32'(valid_o), 32'd1);
      checkOutput("hold_rd", 32'(rd_o), 32'd3);
      checkOutput("hold_rs1_data", rs1_data_o, 32'h12345678);
      checkOutput("hold_ready", 32'(ready_o), 32'd0);
    end
    applyStimulus(0, 32'h002081B3, 1, 0, 0, 0, 32'h55);
    checkOutput("release_valid", 32'(valid_o), 32'd1);
    applyStimulus(0, 32'h002081B3, 1, 0, 0, 0, 32'h55);
    checkOutput("single_issue", 32'(valid_o), 32'd0);
    // jal x5 then flush it
    applyStimulus(1, 32'h010002EF, 0, 0, 0, 0, 32'h66);
    checkOutput("jal_ready", 32'(ready_o), 32'd1);
    applyStimulus(0, 32'h010002EF, 0, 1, 0, 0, 32'h66);
    checkOutput("jal_held", 32'(valid_o), 32'd1);
    checkOutput("flush_ready", 32'(ready_o), 32'd0);
    applyStimulus(1, 32'h00028313, 1, 0, 0, 0, 32'h77);
    checkOutput("flushed_valid", 32'(valid_o), 32'd0);
    checkOutput("x5_not_pending", 32'(ready_o), 32'd1);
    applyStimulus(1, 32'h00000FFF, 1, 0, 0, 0, 32'h88);
    checkOutput("addi_x6_rd", 32'(rd_o), 32'd6);
    checkOutput("illegal_ready", 32'(ready_o), 32'd1);
    applyStimulus(0, 32'h000F8033, 1, 0, 0, 0, 32'h99);
    checkOutput("illegal_flag", 32'(illegal_o), 32'd1);
    checkOutput("illegal_rd", 32'(rd_o), 32'd0);
    checkOutput("illegal_imm", imm_o, 32'd0);
    applyStimulus(0, 32'h000F8033, 1, 0, 0, 0, 32'h99);
    checkOutput("x31_not_pending", 32'(ready_o), 32'd1);
    // reset in the middle of a stall
    applyStimulus(1, 32'h00500093, 0, 0, 0, 0, 32'hAA);
    applyStimulus(1, 32'h000183B3, 0, 0, 0, 0, 32'hBB);
    checkOutput("stall_valid", 32'(valid_o), 32'd1);
    checkOutput("stall_ready", 32'(ready_o), 32'd0);
    #2 rstn_i = 0;
    #1;
    checkOutput("async_reset_valid", 32'(valid_o), 32'd0);
    checkOutput("async_reset_pending", 32'(ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rstn_i = 1;

    // randomised traffic on registers x0..x7
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lastAcc = valid_i && ready_o;
      @(posedge clk);
      #1;
      if (!valid_i || lastAcc) begin
        rnd = $urandom;
        rnd[6:0]   = opTable[$urandom_range(0, 10)];
        rnd[11:7]  = 5'($urandom_range(0, 7));
        rnd[19:15] = 5'($urandom_range(0, 7));
        rnd[24:20] = 5'($urandom_range(0, 7));
        instr_i = rnd;
        pc_i    = $urandom;
        valid_i = ($urandom_range(0, 9) < 8);
      end
      ready_i    = ($urandom_range(0, 9) < 7);
      flush_i    = ($urandom_range(0, 99) < 8);
      wb_valid_i = ($urandom_range(0, 9) < 4);
      wb_rd_i    = 5'($urandom_range(0, 7));
      data_rs1_i = $urandom;
      data_rs2_i = $urandom;
    end

    // drain and make sure nothing is left over
    @(posedge clk);
    #1;
    valid_i = 0; ready_i = 1; flush_i = 0; wb_valid_i = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage between fetch and execute. Splits each instruction into register addresses and immediates, and drives `rs1`/`rs2` to the register file combinationally. It captures the returned operands into a one-entry output register that uses a valid/ready handshake. A 32-entry scoreboard stalls read-after-write hazards until the writeback stage retires the producing write.

## Interface
- `BITSIZE`, 32, datapath width (instructions are always 32 bit)
- `clk`  in  1  clock, rising edge
- `rstn_i`  in  1  asynchronous reset, active low
- `instr_i`  in  32  instruction from fetch
- `pc_i`  in  BITSIZE  PC of `instr_i`
- `valid_i`  in  1  fetch offers `instr_i`
- `ready_o`  out  1  decode accepts this cycle
- `rs1_o`, `rs2_o`  out  5  register file read addresses (= `instr_i[19:15]`, `[24:20]`)
- `data_rs1_i`, `data_rs2_i`  in  BITSIZE  register file read data
- `wb_valid_i`  in  1  writeback retires a register write this cycle
- `wb_rd_i`  in  5  destination being retired
- `flush_i`  in  1  drop the held instruction (taken branch/jump)
- `valid_o`  out  1  output register holds an instruction
- `ready_i`  in  1  execute accepts
- `pc_o`, `rs1_data_o`, `rs2_data_o`, `imm_o`  out  BITSIZE  registered operands and sign-extended immediate
- `rd_o`  out  5  destination; 0 if the instruction does not write
- `opcode_o`  out  7; `funct3_o`  out  3; `funct7b5_o`  out  1  registered control fields
- `illegal_o`  out  1  unknown opcode, qualified by `valid_o`

## Operation
- Opcode classes: R (0110011), I-ALU (0010011), LOAD (0000011), JALR (1100111), STORE (0100011), BRANCH (1100011), LUI (0110111), AUIPC (0010111), JAL (1101111). Any other opcode is illegal.
- Uses rs1: R, I-ALU, LOAD, JALR, STORE, BRANCH.
- Uses rs2: R, STORE, BRANCH.
- Writes rd: R, I-ALU, LOAD, JALR, LUI, AUIPC, JAL, and only when rd≠0. Otherwise `rd_o`=0.
- Immediates are RV32I I/S/B/U/J, sign-extended from bit 31. R-type and illegal instructions give `imm_o`=0.
- Hazard on a used source s≠0 when either holds:
  - `pending[s]` is set and not (`wb_valid_i` and `wb_rd_i`==s);
  - `valid_o` is set, the held instruction writes, and `rd_o`==s.
- A retiring write clears the hazard in the same cycle, because the register file forwards the written value combinationally.
- `ready_o` = !`flush_i` and !hazard and (!`valid_o` or `ready_i`). It depends only on `instr_i` decode and state, never on `valid_i`.
- Accept (`valid_i` and `ready_o`): load all output fields, set `valid_o`.
- Issue (`valid_o` and `ready_i` and !`flush_i`): set `pending[rd_o]` if `rd_o`≠0. With no simultaneous accept, clear `valid_o`.
- Retire (`wb_valid_i`, `wb_rd_i`≠0): clear `pending[wb_rd_i]`. If issue sets the same index in the same cycle, the set wins.
- Flush: next cycle `valid_o`=0, nothing issues, nothing is accepted, scoreboard untouched.
- Illegal instruction: passes downstream with `illegal_o`=1 and `rd_o`=0, and never sets the scoreboard.
- `pending[0]` is always 0.

## Timing
- Reset (async assert, sync release): `valid_o`=0, all outputs 0, `pending`=0. `ready_o` then follows decode of `instr_i`.
- Latency: 1 cycle from accept to `valid_o`. Back-to-back throughput is 1 per cycle when `ready_i`=1 and there is no hazard.
- Dependent back-to-back pair (second instruction reads the first's rd): the second stalls until the first retires. The second is accepted in the retire cycle.
- Output fields are stable while `valid_o`=1 and `ready_i`=0.
- Fetch must hold `instr_i`/`pc_i` stable while `valid_i`=1 and `ready_o`=0.
- Reset mid-stall discards the held instruction and all pending bits.

## Structure
- Package `decode_pkg`: opcode localparams, `imm_type_e` enum (I, S, B, U, J, NONE), decoded control-field struct.
- Sub-module `scoreboard`: 32-bit pending mask with set/clear ports, combinational `busy_rs1`/`busy_rs2` outputs including same-cycle retire bypass. The decode, immediate generation and output register stay in `decode_stage`.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with `ready_i`=1: next cycle `valid_o`=1, `rd_o`=1, `imm_o`=5, `illegal_o`=0.
- `sw x2,-4(x1)` (0xFE20AE23): `imm_o`=0xFFFFFFFC, `rd_o`=0, no pending bit set after issue.
- `addi x1,…` issued, then `add x3,x1,x2`: `ready_o`=0 until `wb_valid_i`=1 with `wb_rd_i`=1. Accept occurs in that same cycle, and `rs1_data_o` equals the written value.
- `ready_i`=0 for 3 cycles with `valid_o`=1: outputs unchanged, `ready_o`=0. Release gives exactly one issue.
- `flush_i` while holding `jal x5,…`: `valid_o`=0 next cycle, `pending[5]` stays 0.
- Opcode 0x7F: `illegal_o`=1, `rd_o`=0, scoreboard unchanged. `rstn_i` low mid-stall: `valid_o`=0 and `pending`=0 immediately.
